// File: rtl/lcd_nibble_reader_pkg.sv
// Shared definitions for the HD44780 4-bit read engine: state encodings,
// 50 MHz default timing and register-select codes.
package lcd_nibble_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_EN_HI  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_GAP    = 3'd4,
    ST_FINISH = 3'd5
  } lcd_state_e;

  typedef enum logic {
    NIB_HI = 1'b0,
    NIB_LO = 1'b1
  } lcd_nibble_e;

  localparam int LCD_SETUP_CYCLES   = 2;
  localparam int LCD_EN_HIGH_CYCLES = 12;
  localparam int LCD_HOLD_CYCLES    = 1;
  localparam int LCD_GAP_CYCLES     = 25;
  localparam int LCD_POLL_LIMIT     = 255;

  localparam logic LCD_RS_CMD  = 1'b0;
  localparam logic LCD_RS_DATA = 1'b1;

  function automatic int lcd_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lcd_nibble_reader_phase_timer.sv
// Loadable down-counter with a zero flag; reloaded on every phase entry so a
// single counter times SETUP, E-high, HOLD and GAP in turn.
module lcd_phase_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_nibble_reader.sv
// HD44780 4-bit bus read engine: drives RS/RW/E, samples two nibbles and
// returns one byte, optionally re-polling the status register until BF=0.
module lcd_nibble_reader
  import lcd_nibble_reader_pkg::*;
#(
  parameter int SETUP_CYCLES   = LCD_SETUP_CYCLES,
  parameter int EN_HIGH_CYCLES = LCD_EN_HIGH_CYCLES,
  parameter int HOLD_CYCLES    = LCD_HOLD_CYCLES,
  parameter int GAP_CYCLES     = LCD_GAP_CYCLES,
  parameter int POLL_LIMIT     = LCD_POLL_LIMIT
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iStart,
  input  logic       iRegisterSelect,
  input  logic       iPoll,
  input  logic [3:0] iLCD,
  output logic       oEnable,
  output logic       oReadWrite,
  output logic       oRegisterSelect,
  output logic       oBusy,
  output logic       oDone,
  output logic [7:0] oData,
  output logic       oTimeout
);

  localparam int MAX_CYC = lcd_max4(SETUP_CYCLES, EN_HIGH_CYCLES, HOLD_CYCLES, GAP_CYCLES);
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int PW      = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;

  localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] EN_LD    = TW'(EN_HIGH_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] POLL_END = PW'(POLL_LIMIT - 1);

  lcd_state_e    state_q, state_d;
  lcd_nibble_e   nib_q, nib_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic          poll_en_q, poll_en_d;
  logic          rs_q, rs_d;
  logic          rw_q, rw_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tmo_q, tmo_d;
  logic [7:0]    data_q, data_d;
  logic [3:0]    hi_q, hi_d;
  logic [3:0]    lo_q, lo_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;
  logic          bf;

  lcd_phase_timer #(
    .W(TW)
  ) u_timer (
    .clk     (Clock),
    .rst     (Reset),
    .load    (tmr_load),
    .load_val(tmr_val),
    .zero    (tmr_zero)
  );

  assign bf = hi_q[3];

  always_comb begin
    state_d    = state_q;
    nib_d      = nib_q;
    poll_cnt_d = poll_cnt_q;
    poll_en_d  = poll_en_q;
    rs_d       = rs_q;
    rw_d       = rw_q;
    en_d       = en_q;
    done_d     = 1'b0;
    tmo_d      = tmo_q;
    data_d     = data_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          rs_d       = (iRegisterSelect && !iPoll) ? LCD_RS_DATA : LCD_RS_CMD;
          poll_en_d  = iPoll;
          poll_cnt_d = '0;
          rw_d       = 1'b1;
          nib_d      = NIB_HI;
          state_d    = ST_SETUP;
          tmr_load   = 1'b1;
          tmr_val    = SETUP_LD;
        end
      end

      ST_SETUP: begin
        if (tmr_zero) begin
          en_d     = 1'b1;
          state_d  = ST_EN_HI;
          tmr_load = 1'b1;
          tmr_val  = EN_LD;
        end
      end

      ST_EN_HI: begin
        // Panel data is valid late in the E pulse, so capture on its last cycle.
        if (tmr_zero) begin
          if (nib_q == NIB_HI) begin
            hi_d = iLCD;
          end else begin
            lo_d = iLCD;
          end
          en_d     = 1'b0;
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end

      ST_HOLD: begin
        if (tmr_zero) begin
          if (nib_q == NIB_HI) begin
            nib_d    = NIB_LO;
            state_d  = ST_GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
          end else if (!poll_en_q || !bf || (poll_cnt_q == POLL_END)) begin
            // Completion folds into this edge; there is no separate FINISH cycle.
            data_d    = {hi_q, lo_q};
            tmo_d     = poll_en_q & bf;
            done_d    = 1'b1;
            rw_d      = 1'b0;
            rs_d      = LCD_RS_CMD;
            poll_en_d = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            poll_cnt_d = poll_cnt_q + PW'(1);
            nib_d      = NIB_HI;
            state_d    = ST_GAP;
            tmr_load   = 1'b1;
            tmr_val    = GAP_LD;
          end
        end
      end

      ST_GAP: begin
        if (tmr_zero) begin
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      nib_q      <= NIB_HI;
      poll_cnt_q <= '0;
      poll_en_q  <= 1'b0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      data_q     <= 8'h00;
      hi_q       <= 4'h0;
      lo_q       <= 4'h0;
    end else begin
      state_q    <= state_d;
      nib_q      <= nib_d;
      poll_cnt_q <= poll_cnt_d;
      poll_en_q  <= poll_en_d;
      rs_q       <= rs_d;
      rw_q       <= rw_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
      data_q     <= data_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign oEnable         = en_q;
  assign oReadWrite      = rw_q;
  assign oRegisterSelect = rs_q;
  assign oBusy           = busy_q;
  assign oDone           = done_q;
  assign oData           = data_q;
  assign oTimeout        = tmo_q;

endmodule

// File: tb/tb_lcd_nibble_reader.sv
// Directed bench for lcd_nibble_reader: a panel model feeds nibbles per E pulse
// and each step checks timing, data and control against hand-derived values.
module tb_lcd_nibble_reader;

  logic       clk = 1'b0;
  logic       rst, start, rs_in, poll_in;
  logic [3:0] lcd;

  logic       en_a, rw_a, rso_a, busy_a, done_a, tmo_a;
  logic [7:0] data_a;
  logic       en_b, rw_b, rso_b, busy_b, done_b, tmo_b;
  logic [7:0] data_b;

  logic       sel;
  logic       o_en, o_rw, o_rs, o_busy, o_done, o_tmo;
  logic [7:0] o_data;

  int         nvec = 0;
  int         nerr = 0;

  logic [7:0] tbl [4];
  int         tlen;
  int         nib;
  logic       prev_e;

  always #10 clk = ~clk;

  lcd_nibble_reader dut (
    .Clock(clk), .Reset(rst), .iStart(start), .iRegisterSelect(rs_in), .iPoll(poll_in),
    .iLCD(lcd), .oEnable(en_a), .oReadWrite(rw_a), .oRegisterSelect(rso_a),
    .oBusy(busy_a), .oDone(done_a), .oData(data_a), .oTimeout(tmo_a)
  );

  lcd_nibble_reader #(.POLL_LIMIT(3)) dut3 (
    .Clock(clk), .Reset(rst), .iStart(start), .iRegisterSelect(rs_in), .iPoll(poll_in),
    .iLCD(lcd), .oEnable(en_b), .oReadWrite(rw_b), .oRegisterSelect(rso_b),
    .oBusy(busy_b), .oDone(done_b), .oData(data_b), .oTimeout(tmo_b)
  );

  assign o_en   = sel ? en_b   : en_a;
  assign o_rw   = sel ? rw_b   : rw_a;
  assign o_rs   = sel ? rso_b  : rso_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_tmo  = sel ? tmo_b  : tmo_a;
  assign o_data = sel ? data_b : data_a;

  // Panel model: each falling E advances to the next nibble of the byte list.
  initial begin
    logic       e;
    logic [7:0] cur;
    int         idx;
    forever begin
      @(negedge clk);
      e = o_en;
      if (prev_e && !e) nib++;
      prev_e = e;
      idx = nib / 2;
      if (idx >= tlen) idx = tlen - 1;
      cur = tbl[idx];
      lcd = (nib % 2 == 1) ? cur[3:0] : cur[7:4];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    nib = 0;
    prev_e = 1'b0;
    tick();
  endtask

  task automatic go(input logic rs, input logic poll);
    rs_in   = rs;
    poll_in = poll;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Called just after edge 0; walks edges until oDone or the budget expires.
  task automatic run_read(input int maxe, input logic rs_exp, input int inj,
                          output int done_e, output int e_first, output int e_tot,
                          output bit runs_ok, output bit ctl_ok);
    int run;
    done_e = -1; e_first = -1; e_tot = 0; run = 0; runs_ok = 1'b1; ctl_ok = 1'b1;
    for (int k = 0; k <= maxe; k++) begin
      if (k > 0) tick();
      if (k == inj) begin start = 1'b1; rs_in = 1'b0; end
      if (k == inj + 1) start = 1'b0;
      if (o_done === 1'b1) begin
        done_e = k;
        if (o_rw !== 1'b0 || o_rs !== 1'b0 || o_busy !== 1'b0 || o_en !== 1'b0) ctl_ok = 1'b0;
        break;
      end
      if (o_rw !== 1'b1 || o_busy !== 1'b1 || o_rs !== rs_exp) ctl_ok = 1'b0;
      if (o_en === 1'b1) begin
        if (e_first < 0) e_first = k;
        e_tot++;
        run++;
      end else begin
        if (run != 0 && run != 12) runs_ok = 1'b0;
        run = 0;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int done_e, e_first, e_tot, seen;
    bit runs_ok, ctl_ok;

    rst = 1'b1; start = 1'b0; rs_in = 1'b0; poll_in = 1'b0; lcd = 4'h0; sel = 1'b0;
    tbl[0] = 8'h00; tbl[1] = 8'h00; tbl[2] = 8'h00; tbl[3] = 8'h00; tlen = 1;
    nib = 0; prev_e = 1'b0;

    // Reset and idle
    do_reset();
    repeat (20) tick();
    check("idle_en",   32'(o_en),   0);
    check("idle_rw",   32'(o_rw),   0);
    check("idle_rs",   32'(o_rs),   0);
    check("idle_busy", 32'(o_busy), 0);
    check("idle_done", 32'(o_done), 0);
    check("idle_tmo",  32'(o_tmo),  0);
    check("idle_data", 32'(o_data), 0);

    // Single status read 3A
    do_reset();
    tbl[0] = 8'h3A; tlen = 1;
    go(1'b0, 1'b0);
    run_read(300, 1'b0, -10, done_e, e_first, e_tot, runs_ok, ctl_ok);
    check("st_done_edge", 32'(done_e),  55);
    check("st_data",      32'(o_data),  32'h3A);
    check("st_tmo",       32'(o_tmo),   0);
    check("st_e_first",   32'(e_first), 2);
    check("st_e_total",   32'(e_tot),   24);
    check("st_e_runs",    32'(runs_ok), 1);
    check("st_ctl",       32'(ctl_ok),  1);

    // Busy poll: 80, 80, 05 (RS requested but forced to command)
    do_reset();
    tbl[0] = 8'h80; tbl[1] = 8'h80; tbl[2] = 8'h05; tlen = 3;
    go(1'b1, 1'b1);
    run_read(600, 1'b0, -10, done_e, e_first, e_tot, runs_ok, ctl_ok);
    check("poll_done_edge", 32'(done_e),  215);
    check("poll_data",      32'(o_data),  32'h05);
    check("poll_tmo",       32'(o_tmo),   0);
    check("poll_e_total",   32'(e_tot),   72);
    check("poll_ctl",       32'(ctl_ok),  1);

    // Poll limit 3 with a permanently busy panel
    sel = 1'b1;
    do_reset();
    tbl[0] = 8'hFF; tlen = 1;
    go(1'b0, 1'b1);
    run_read(600, 1'b0, -10, done_e, e_first, e_tot, runs_ok, ctl_ok);
    check("lim_done_edge", 32'(done_e), 215);
    check("lim_tmo",       32'(o_tmo),  1);
    check("lim_data",      32'(o_data), 32'hFF);
    check("lim_e_total",   32'(e_tot),  72);
    check("lim_ctl",       32'(ctl_ok), 1);
    sel = 1'b0;

    // Data read with ignored mid-op start, then a start in the oDone cycle
    do_reset();
    tbl[0] = 8'hC5; tbl[1] = 8'h9B; tlen = 2;
    go(1'b1, 1'b0);
    run_read(300, 1'b1, 20, done_e, e_first, e_tot, runs_ok, ctl_ok);
    check("dat1_done_edge", 32'(done_e), 55);
    check("dat1_data",      32'(o_data), 32'hC5);
    check("dat1_ctl",       32'(ctl_ok), 1);
    check("dat1_done_now",  32'(o_done), 1);
    go(1'b1, 1'b0);
    run_read(300, 1'b1, -10, done_e, e_first, e_tot, runs_ok, ctl_ok);
    check("dat2_done_edge", 32'(done_e), 55);
    check("dat2_data",      32'(o_data), 32'h9B);
    check("dat2_ctl",       32'(ctl_ok), 1);

    // Reset during E high at edge 8
    tbl[0] = 8'h3A; tlen = 1; nib = 0;
    go(1'b0, 1'b0);
    repeat (7) tick();
    check("rst_e_before", 32'(o_en), 1);
    rst = 1'b1;
    tick();
    check("rst_en",   32'(o_en),   0);
    check("rst_rw",   32'(o_rw),   0);
    check("rst_busy", 32'(o_busy), 0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (o_done === 1'b1) seen++;
    end
    check("rst_no_done", 32'(seen),   0);
    check("rst_data",    32'(o_data), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
